sm_fetch_queue: RTL and testbench

SM_FETCH_QUEUE -- requirements
Module: sm_fetch_queue

---
 rtl/sm_fetch_queue.sv | 108 ++++++++++
 tb/tb_sm_fetch_queue.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sm_fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sm_fetch_queue                                                |
// | Brief    : Instruction prefetch queue in front of a synchronous ROM.     |
// |            Credits cover queued and in-flight entries.                   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module sm_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          IMEM_AW  = 6,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         redirect,
  input  logic [31:0]                  redirect_pc,
  output logic                         imem_req,
  output logic [IMEM_AW-1:0]           imem_addr,
  input  logic [31:0]                  imem_rdata,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_pc,
  output logic [31:0]                  out_instr,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0]   c_DEPTH   = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] c_FULL    = CW'(DEPTH);
  localparam logic [PW-1:0] c_PTR_ONE = PW'(1);

  logic [31:0]   r_fetchPc;
  logic [31:0]   r_reqPc;
  logic          r_inflight;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [31:0]   r_pcMem    [DEPTH];
  logic [31:0]   r_instrMem [DEPTH];

  logic w_credit;
  logic w_push;
  logic w_pop;

  // The in-flight request reserves a slot, so a response always finds room.
  assign w_credit  = ({1'b0, r_count} + (CW+1)'(r_inflight)) < c_DEPTH;
  assign imem_req  = !rst && !redirect && w_credit;
  assign imem_addr = r_fetchPc[IMEM_AW+1:2];

  assign w_push    = r_inflight && !redirect;
  assign out_valid = (r_count != '0) && !redirect;
  assign w_pop     = out_valid && out_ready;

  assign out_pc    = r_pcMem[r_head];
  assign out_instr = r_instrMem[r_head];
  assign count     = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetchPc  <= RESET_PC;
      r_reqPc    <= RESET_PC;
      r_inflight <= 1'b0;
    end else if (redirect) begin
      r_fetchPc  <= redirect_pc & 32'hFFFF_FFFC;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= imem_req;
      if (imem_req) begin
        r_reqPc   <= r_fetchPc;
        r_fetchPc <= r_fetchPc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (redirect) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + c_PTR_ONE;
      if (w_pop)  r_head <= r_head + c_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pcMem[r_tail]    <= r_reqPc;
      r_instrMem[r_tail] <= imem_rdata;
    end
  end

  a_noPushWhenFull: assert property (@(posedge clk) disable iff (rst)
    !(w_push && (r_count == c_FULL)));

endmodule
`default_nettype wire

// File: tb/tb_sm_fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sm_fetch_queue                                             |
// | Brief    : Vector table, corner sequences and random stalls vs. model.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_sm_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          IMEM_AW  = 6;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          CW       = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              redirect = 1'b0;
  logic [31:0]       redirect_pc = '0;
  logic              imem_req;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]       imem_rdata = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_pc;
  logic [31:0]       out_instr;
  logic [CW-1:0]     count;

  sm_fetch_queue #(.DEPTH(DEPTH), .IMEM_AW(IMEM_AW), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .count(count)
  );

  always #5 clk = ~clk;

  // ROM word i holds i; data registered one cycle after the address.
  always @(posedge clk) imem_rdata <= 32'(imem_addr);

  int nCmp = 0;
  int nBad = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] romWord(logic [31:0] pc);
    return 32'(pc[IMEM_AW+1:2]);
  endfunction

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        eReq;
    logic [31:0] eFpc;
    logic        eValid;
    logic [31:0] ePc;
    int          eCount;
  } vec_t;

  vec_t tbl[14];

  // Abstract model: requests outstanding since last flush, next pcs to fetch/deliver.
  int          mOut;
  logic        mLastReq;
  logic [31:0] mFetch;
  logic [31:0] mHead;

  task automatic modelReset(input logic [31:0] pc);
    mOut = 0; mLastReq = 1'b0; mFetch = pc; mHead = pc;
  endtask

  task automatic stepModel(input logic redir, input logic [31:0] rpc, input logic ready);
    logic eReq, eValid;
    int   eCount;
    redirect = redir; redirect_pc = rpc; out_ready = ready;
    #1;
    eReq   = !redir && (mOut < DEPTH);
    eCount = mOut - (mLastReq ? 1 : 0);
    eValid = (eCount != 0) && !redir;
    chk("m_req", 32'(imem_req), 32'(eReq));
    if (eReq) chk("m_addr", 32'(imem_addr), romWord(mFetch));
    chk("m_count", 32'(count), 32'(eCount));
    chk("m_valid", 32'(out_valid), 32'(eValid));
    if (eValid) begin
      chk("m_pc", out_pc, mHead);
      chk("m_instr", out_instr, romWord(mHead));
    end
    if (redir) begin
      modelReset(rpc & 32'hFFFF_FFFC);
    end else begin
      if (eReq) begin mOut++; mFetch = mFetch + 32'd4; end
      if (eValid && ready) begin mOut--; mHead = mHead + 32'd4; end
      mLastReq = eReq;
    end
    @(negedge clk);
  endtask

  initial begin
    //           redir rpc       rdy req fetchpc  vld pc        cnt
    tbl[0]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h00, 1'b0, 32'h00, 0};
    tbl[1]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h04, 1'b0, 32'h00, 0};
    tbl[2]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h08, 1'b1, 32'h00, 1};
    tbl[3]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h0C, 1'b1, 32'h00, 2};
    tbl[4]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h00, 1'b1, 32'h00, 3};
    tbl[5]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h00, 1'b1, 32'h00, 4};
    tbl[6]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h00, 1'b1, 32'h00, 4};
    tbl[7]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h10, 1'b1, 32'h04, 3};
    tbl[8]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h14, 1'b1, 32'h08, 2};
    tbl[9]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h18, 1'b1, 32'h0C, 2};
    tbl[10] = '{1'b1, 32'h43, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 2};
    tbl[11] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h40, 1'b0, 32'h00, 0};
    tbl[12] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h44, 1'b0, 32'h00, 0};
    tbl[13] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h48, 1'b1, 32'h40, 1};

    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);

    rst = 1'b0;
    foreach (tbl[i]) begin
      redirect = tbl[i].redir; redirect_pc = tbl[i].rpc; out_ready = tbl[i].ready;
      #1;
      chk($sformatf("t%0d_req", i), 32'(imem_req), 32'(tbl[i].eReq));
      if (tbl[i].eReq) chk($sformatf("t%0d_addr", i), 32'(imem_addr), romWord(tbl[i].eFpc));
      chk($sformatf("t%0d_valid", i), 32'(out_valid), 32'(tbl[i].eValid));
      if (tbl[i].eValid) begin
        chk($sformatf("t%0d_pc", i), out_pc, tbl[i].ePc);
        chk($sformatf("t%0d_instr", i), out_instr, romWord(tbl[i].ePc));
      end
      chk($sformatf("t%0d_count", i), 32'(count), 32'(tbl[i].eCount));
      @(negedge clk);
    end

    // Asynchronous reset mid-stream: outputs drop before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    @(negedge clk);
    chk("arst_hold_count", 32'(count), 32'd0);
    rst = 1'b0;
    modelReset(RESET_PC);

    // Fill to three queued plus one in flight, then flush twice; last redirect wins.
    repeat (4) stepModel(1'b0, 32'h0, 1'b0);
    chk("pre_redir_count", 32'(count), 32'd3);
    stepModel(1'b1, 32'h80, 1'b0);
    stepModel(1'b1, 32'hFFFF_FFFA, 1'b0);
    repeat (8) stepModel(1'b0, 32'h0, 1'b1);

    // Random stalls with occasional redirects to arbitrary addresses.
    for (int c = 0; c < 1000; c++) begin
      logic rd;
      rd = ($urandom_range(0, 49) == 0);
      stepModel(rd, $urandom, ($urandom_range(0, 2) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
`default_nettype wire
